// File: rtl/sound_glu_pkg.sv
// Shared definitions for the IIgs sound GLU: reader FSM states, sound RAM
// placement inside SDRAM, and the $C03C-$C03F register map.
package sound_glu_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    WAIT    = 3'd2,
    CAPTURE = 3'd3,
    SETTLE  = 3'd4
  } reader_state_e;

  // Upper SDRAM word-address bits placing the 64K DOC RAM at word 0x1_0000.
  localparam logic [6:0] SOUND_RAM_WORD_BASE = {4'b0, 1'b1, 2'b0};

  localparam logic [15:0] GLU_REG_CTRL    = 16'hC03C;
  localparam logic [15:0] GLU_REG_DATA    = 16'hC03D;
  localparam logic [15:0] GLU_REG_ADDR_LO = 16'hC03E;
  localparam logic [15:0] GLU_REG_ADDR_HI = 16'hC03F;

  function automatic logic [20:0] sound_word_addr(input logic [15:0] byte_ptr);
    return {SOUND_RAM_WORD_BASE, byte_ptr[15:2]};
  endfunction

  function automatic logic [7:0] byte_lane(input logic [31:0] word,
                                           input logic [1:0]  sel);
    logic [7:0] lane;
    case (sel)
      2'd0:    lane = word[7:0];
      2'd1:    lane = word[15:8];
      2'd2:    lane = word[23:16];
      default: lane = word[31:24];
    endcase
    return lane;
  endfunction

endpackage

// File: rtl/sdram_port_if.sv
// One SDRAM arbiter client port: 21-bit word address, 32-bit data, byte enables.
interface sdram_port_if;
  logic        rd;
  logic        wr;
  logic [20:0] addr;
  logic [3:0]  byte_en;
  logic [31:0] data;
  logic        ready;
  logic [31:0] q;

  modport client (
    output rd, wr, addr, byte_en, data,
    input  ready, q
  );

  modport controller (
    input  rd, wr, addr, byte_en, data,
    output ready, q
  );
endinterface

// File: rtl/sound_ram_reader.sv
// Read side of the GLU sound RAM window: CPU reads of $C03D return the byte
// latched by the previous fetch, then the byte at the current pointer is fetched.
module sound_ram_reader
  import sound_glu_pkg::*;
#(
  parameter logic        ENABLE         = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk_logic,
  input  logic        system_reset_n,
  input  logic        rd_strobe_i,
  input  logic        wr_strobe_i,
  input  logic [7:0]  wr_data_i,
  input  logic        ptr_load_i,
  input  logic [15:0] ptr_i,
  input  logic        auto_inc_i,
  output logic [7:0]  data_o,
  output logic        inc_o,
  output logic        busy_o,
  output logic        overrun_o,
  output logic        timeout_o,
  sdram_port_if.client mem_if
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  reader_state_e    state_q;
  logic [15:0]      addr_q;
  logic [31:0]      word_q;
  logic [CNT_W-1:0] tcnt_q;
  logic             reload_q;
  logic             pending_q;
  logic             cancel_q;
  logic [7:0]       data_q;
  logic             inc_q;
  logic             overrun_q;
  logic             timeout_q;
  logic             rd_q;

  logic        rd_ok;
  logic        pend_full;
  logic        go_settle;
  logic [15:0] fetch_ptr_d;

  assign rd_ok     = ENABLE && rd_strobe_i;
  // SETTLE consumes the pending read, so a strobe there re-arms instead of overrunning.
  assign pend_full = pending_q && (state_q != SETTLE);
  assign go_settle = pending_q || rd_ok;

  // The GLU applies inc_o one edge after SETTLE, so a reloaded fetch takes the
  // live pointer during REQ; otherwise the address latched at acceptance is used.
  assign fetch_ptr_d = (state_q == REQ && reload_q) ? ptr_i : addr_q;

  always_ff @(posedge clk_logic or negedge system_reset_n) begin
    if (!system_reset_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      word_q    <= '0;
      tcnt_q    <= '0;
      reload_q  <= 1'b0;
      pending_q <= 1'b0;
      cancel_q  <= 1'b0;
      data_q    <= 8'h00;
      inc_q     <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
      rd_q      <= 1'b0;
    end else begin
      inc_q <= 1'b0;
      rd_q  <= 1'b0;

      if (ptr_load_i) begin
        overrun_q <= 1'b0;
        timeout_q <= 1'b0;
      end

      if (rd_ok && state_q != IDLE) begin
        if (pend_full) overrun_q <= 1'b1;
        else           pending_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (rd_ok) begin
            addr_q   <= ptr_i;
            reload_q <= 1'b0;
            cancel_q <= 1'b0;
            rd_q     <= 1'b1;
            state_q  <= REQ;
          end
        end

        REQ: begin
          addr_q   <= fetch_ptr_d;
          reload_q <= 1'b0;
          tcnt_q   <= '0;
          state_q  <= WAIT;
        end

        WAIT: begin
          if (mem_if.ready) begin
            word_q  <= mem_if.q;
            state_q <= CAPTURE;
          end else if (tcnt_q == CNT_LAST) begin
            timeout_q <= 1'b1;
            pending_q <= 1'b0;
            state_q   <= IDLE;
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end

        CAPTURE: begin
          if (!cancel_q) begin
            data_q <= byte_lane(word_q, addr_q[1:0]);
            inc_q  <= auto_inc_i;
          end
          cancel_q <= 1'b0;
          state_q  <= go_settle ? SETTLE : IDLE;
        end

        SETTLE: begin
          addr_q    <= ptr_i;
          reload_q  <= 1'b1;
          pending_q <= rd_ok;
          rd_q      <= 1'b1;
          state_q   <= REQ;
        end

        default: state_q <= IDLE;
      endcase

      // CPU writes always land, and void any fetch that is still on the bus.
      if (wr_strobe_i) begin
        data_q <= wr_data_i;
        if (state_q == REQ || state_q == WAIT) cancel_q <= 1'b1;
      end
    end
  end

  assign data_o    = data_q;
  assign inc_o     = inc_q;
  assign busy_o    = (state_q != IDLE);
  assign overrun_o = overrun_q;
  assign timeout_o = timeout_q;

  assign mem_if.rd      = rd_q;
  assign mem_if.wr      = 1'b0;
  assign mem_if.addr    = sound_word_addr(fetch_ptr_d);
  assign mem_if.byte_en = 4'b1111;
  assign mem_if.data    = 32'h0;

endmodule
